// File: rtl/lapido_control_fsm.sv
// Multi-cycle Lapido controller: FETCH/DECODE/EXEC/MEM/WB sequencing with registered datapath controls.
// Define LAPIDO_CTRL_PERF_EN to build the retired-instruction counter; otherwise retired is tied to 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | instr_ready high, waiting for instr_valid to load IR
// S_DECODE | decode controls from IR, trap on illegal encoding
// S_EXEC   | ALU/LOADLIT to WB, LOAD/STORE to MEM, NOP/branch retire
// S_MEM    | mem_req held until mem_ack or wait counter expires
// S_WB     | register write and PC advance
// S_TRAP   | fault held until fault_clr
module lapido_control_fsm #(
   parameter int INSTR_W     = 32,
   parameter int ALUOP_W     = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic               mem_req,
   input  logic               mem_ack,
   input  logic               fault_clr,
   output logic               branch,
   output logic               mem_read_n,
   output logic               mem_write_n,
   output logic               mem_to_reg,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               alu_src,
   output logic               reg_write,
   output logic               register_b,
   output logic               pc_en,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic [CNT_W-1:0]   retired
);
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   state_t state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [1:0]         fault_code_q, fault_code_d;
   logic               accept;

   logic instr_ready_q, instr_ready_d, mem_req_q, mem_req_d, branch_q, branch_d;
   logic mem_read_n_q, mem_read_n_d, mem_write_n_q, mem_write_n_d;
   logic mem_to_reg_q, mem_to_reg_d, alu_src_q, alu_src_d, reg_write_q, reg_write_d;
   logic register_b_q, register_b_d, pc_en_q, pc_en_d, fault_q, fault_d;
   logic [ALUOP_W-1:0] alu_op_q, alu_op_d;

   logic [2:0]         dec_cls;
   logic [4:0]         dec_func;
   logic               dec_legal, dec_alu_src, dec_register_b, dec_load, dec_store;
   logic               dec_to_wb, dec_ctrl, dec_in_flight;
   logic [ALUOP_W-1:0] dec_alu_op;

   // Decode from ir_d so DECODE-cycle controls are valid as soon as IR is loaded.
   assign accept   = (state_q == S_FETCH) && instr_ready_q && instr_valid;
   assign ir_d     = accept ? instr : ir_q;
   assign dec_cls  = ir_d[INSTR_W-1 -: 3];
   assign dec_func = ir_d[INSTR_W-4 -: 5];

   always_comb begin
      dec_legal      = 1'b0;
      dec_alu_op     = '0;
      dec_alu_src    = 1'b0;
      dec_register_b = 1'b0;
      dec_load       = 1'b0;
      dec_store      = 1'b0;
      dec_to_wb      = 1'b0;
      dec_ctrl       = 1'b0;
      case (dec_cls)
         3'b000: dec_legal = 1'b1;
         3'b001: begin
            dec_legal  = 1'b1;
            dec_alu_op = ALUOP_W'(dec_func);
            dec_to_wb  = 1'b1;
         end
         3'b010: begin
            if (dec_func[1:0] == 2'b10) begin
               dec_legal   = 1'b1;
               dec_alu_src = 1'b1;
               dec_alu_op  = ALUOP_W'(5'b10011);
               dec_to_wb   = 1'b1;
            end
         end
         3'b100: begin
            dec_legal   = 1'b1;
            dec_alu_src = 1'b1;
            dec_load    = ~dec_func[0];
            dec_store   = dec_func[0];
            dec_to_wb   = ~dec_func[0];
         end
         3'b101: begin
            dec_legal      = (dec_func[4:2] == 3'b000) || (dec_func[4:2] == 3'b001) ||
                             (dec_func[4:2] == 3'b010);
            dec_ctrl       = dec_legal;
            dec_register_b = dec_legal;
            case (dec_func[4:2])
               3'b000:  dec_alu_op = ALUOP_W'(5'b01010);
               3'b001:  dec_alu_op = ALUOP_W'(5'b00010);
               3'b010:  dec_alu_op = ALUOP_W'(5'b00111);
               default: dec_alu_op = '0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      fault_code_d = fault_code_q;
      case (state_q)
         S_FETCH:  if (accept) state_d = S_DECODE;
         S_DECODE: begin
            if (dec_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d      = S_TRAP;
               fault_code_d = 2'b01;
            end
         end
         S_EXEC: begin
            wait_d = '0;
            if (dec_load || dec_store) state_d = S_MEM;
            else if (dec_to_wb)        state_d = S_WB;
            else                       state_d = S_FETCH;
         end
         S_MEM: begin
            if (mem_ack) begin
               state_d = dec_store ? S_FETCH : S_WB;
            end else if (wait_q == WAIT_LAST) begin
               state_d      = S_TRAP;
               fault_code_d = 2'b10;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB:   state_d = S_FETCH;
         S_TRAP: begin
            if (fault_clr) begin
               state_d      = S_FETCH;
               fault_code_d = 2'b00;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Every output register is loaded with the value belonging to the state being entered.
   always_comb begin
      dec_in_flight = (state_d == S_DECODE) || (state_d == S_EXEC) ||
                      (state_d == S_MEM) || (state_d == S_WB);
      instr_ready_d = (state_d == S_FETCH);
      mem_req_d     = (state_d == S_MEM);
      mem_read_n_d  = ~((state_d == S_MEM) && dec_load);
      mem_write_n_d = ~((state_d == S_MEM) && dec_store);
      branch_d      = (state_d == S_EXEC) && dec_ctrl;
      reg_write_d   = (state_d == S_WB);
      fault_d       = (state_d == S_TRAP);
      alu_op_d      = dec_in_flight ? dec_alu_op : '0;
      alu_src_d     = dec_in_flight && dec_alu_src;
      register_b_d  = dec_in_flight && dec_register_b;
      mem_to_reg_d  = dec_in_flight && dec_load;
      pc_en_d       = ((state_d == S_EXEC) && !dec_load && !dec_store && !dec_to_wb) ||
                      (state_d == S_WB) ||
                      ((state_q == S_MEM) && mem_ack && dec_store);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= S_FETCH;
         ir_q          <= '0;
         wait_q        <= '0;
         fault_code_q  <= 2'b00;
         instr_ready_q <= 1'b0;
         mem_req_q     <= 1'b0;
         branch_q      <= 1'b0;
         mem_read_n_q  <= 1'b1;
         mem_write_n_q <= 1'b1;
         mem_to_reg_q  <= 1'b0;
         alu_op_q      <= '0;
         alu_src_q     <= 1'b0;
         reg_write_q   <= 1'b0;
         register_b_q  <= 1'b0;
         pc_en_q       <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         wait_q        <= wait_d;
         fault_code_q  <= fault_code_d;
         instr_ready_q <= instr_ready_d;
         mem_req_q     <= mem_req_d;
         branch_q      <= branch_d;
         mem_read_n_q  <= mem_read_n_d;
         mem_write_n_q <= mem_write_n_d;
         mem_to_reg_q  <= mem_to_reg_d;
         alu_op_q      <= alu_op_d;
         alu_src_q     <= alu_src_d;
         reg_write_q   <= reg_write_d;
         register_b_q  <= register_b_d;
         pc_en_q       <= pc_en_d;
         fault_q       <= fault_d;
      end
   end

   assign instr_ready = instr_ready_q;
   assign mem_req     = mem_req_q;
   assign branch      = branch_q;
   assign mem_read_n  = mem_read_n_q;
   assign mem_write_n = mem_write_n_q;
   assign mem_to_reg  = mem_to_reg_q;
   assign alu_op      = alu_op_q;
   assign alu_src     = alu_src_q;
   assign reg_write   = reg_write_q;
   assign register_b  = register_b_q;
   assign pc_en       = pc_en_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;

`ifdef LAPIDO_CTRL_PERF_EN
   logic [CNT_W-1:0] retired_q;

   always_ff @(posedge clock) begin
      if (!reset_n)     retired_q <= '0;
      else if (pc_en_d) retired_q <= retired_q + CNT_W'(1);
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_lapido_control_fsm.sv
// Directed bench for lapido_control_fsm: decode table plus memory wait, timeout, trap and reset sequences.
module tb_lapido_control_fsm;
   localparam int INSTR_W     = 32;
   localparam int ALUOP_W     = 5;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 16;
`ifdef LAPIDO_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   // {instr_ready,mem_req,branch,mem_read_n,mem_write_n,mem_to_reg,alu_op,alu_src,reg_write,register_b,pc_en,fault,fault_code}
   localparam logic [31:0] RST_OUTS = 32'h0000_6000;

   logic               clock, reset_n, instr_valid, instr_ready, mem_req, mem_ack, fault_clr;
   logic               branch, mem_read_n, mem_write_n, mem_to_reg, alu_src, reg_write;
   logic               register_b, pc_en, fault;
   logic [INSTR_W-1:0] instr;
   logic [ALUOP_W-1:0] alu_op;
   logic [1:0]         fault_code;
   logic [CNT_W-1:0]   retired;

   lapido_control_fsm #(
      .INSTR_W(INSTR_W), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .mem_req(mem_req), .mem_ack(mem_ack), .fault_clr(fault_clr),
      .branch(branch), .mem_read_n(mem_read_n), .mem_write_n(mem_write_n),
      .mem_to_reg(mem_to_reg), .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
      .register_b(register_b), .pc_en(pc_en), .fault(fault), .fault_code(fault_code),
      .retired(retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  op;
      bit          src, rb, m2r, ill;
      int          lat, n_pc, n_rw, n_br, n_rd, n_wr;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0, n_bad = 0;
   int   n_cyc, exited, exp_ret;
   int   t_pc, t_rw, t_br, t_rd, t_wr, t_mr, t_brpc, t_wbm2r;
   logic [4:0] d_op, br_op;
   logic d_src, d_rb, d_m2r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {14'd0, instr_ready, mem_req, branch, mem_read_n, mem_write_n, mem_to_reg,
              alu_op, alu_src, reg_write, register_b, pc_en, fault, fault_code};
   endfunction

   task automatic chk_retired(input string name);
      chk(name, 32'(retired), PERF ? 32'(exp_ret) : 32'd0);
   endtask

   task automatic issue(input logic [31:0] ins);
      int k = 0;
      while (!instr_ready && k < 10) begin
         @(posedge clock); #1;
         k++;
      end
      chk("issue_ready", 32'(instr_ready), 32'd1);
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      instr = '0;
   endtask

   // Runs one instruction from accept until FETCH or TRAP; ack_at = MEM cycle to raise mem_ack in (0 = never).
   task automatic run_instr(input logic [31:0] ins, input int ack_at);
      issue(ins);
      t_pc = 0; t_rw = 0; t_br = 0; t_rd = 0; t_wr = 0; t_mr = 0; t_brpc = 0; t_wbm2r = 0;
      exited = 0; n_cyc = 1; br_op = '0;
      d_op = alu_op; d_src = alu_src; d_rb = register_b; d_m2r = mem_to_reg;
      while (n_cyc < 40) begin
         if (pc_en) t_pc++;
         if (reg_write) t_rw++;
         if (!mem_read_n) t_rd++;
         if (!mem_write_n) t_wr++;
         if (mem_req) t_mr++;
         if (branch) begin
            t_br++;
            br_op = alu_op;
            if (pc_en) t_brpc++;
         end
         if (reg_write && mem_to_reg) t_wbm2r++;
         if (instr_ready || fault) begin
            exited = 1;
            break;
         end
         if (ack_at != 0 && t_mr == ack_at) mem_ack = 1'b1;
         @(posedge clock); #1;
         n_cyc++;
      end
      mem_ack = 1'b0;
      chk("exit_bounded", 32'(exited), 32'd1);
   endtask

   task automatic clear_trap();
      fault_clr = 1'b1;
      @(posedge clock); #1;
      fault_clr = 1'b0;
      chk("clr_fault", 32'(fault), 32'd0);
      chk("clr_code", 32'(fault_code), 32'd0);
      chk("clr_ready", 32'(instr_ready), 32'd1);
   endtask

   initial begin
      reset_n = 1'b0; instr = '0; instr_valid = 1'b0; mem_ack = 1'b0; fault_clr = 1'b0;
      exp_ret = 0;
      //                instr          op   src   rb    m2r   ill  lat pc rw br rd wr
      tbl.push_back('{32'h2000_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 0, 0});
      tbl.push_back('{32'h3F00_0000, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 0, 0});
      tbl.push_back('{32'h8000_0000, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5, 1, 1, 0, 1, 0});
      tbl.push_back('{32'h8100_0000, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1, 0, 0, 0, 1});
      tbl.push_back('{32'h4200_0000, 5'h13, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 0, 0});
      tbl.push_back('{32'h5E00_0000, 5'h13, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1, 1, 0, 0, 0});
      tbl.push_back('{32'h0000_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, 0, 0, 0, 0});
      tbl.push_back('{32'h1F00_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, 0, 0, 0, 0});
      tbl.push_back('{32'hA000_0000, 5'h0A, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 0, 1, 0, 0});
      tbl.push_back('{32'hA400_0000, 5'h02, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 0, 1, 0, 0});
      tbl.push_back('{32'hA700_0000, 5'h02, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 0, 1, 0, 0});
      tbl.push_back('{32'hA800_0000, 5'h07, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 0, 1, 0, 0});
      tbl.push_back('{32'hE000_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0, 0, 0});
      tbl.push_back('{32'h4000_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0, 0, 0});
      tbl.push_back('{32'hAC00_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0, 0, 0});
      tbl.push_back('{32'h6000_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0, 0, 0});
      tbl.push_back('{32'hC000_0000, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0, 0, 0});

      repeat (3) @(posedge clock);
      #1;
      chk("reset_outs", outs(), RST_OUTS);
      chk("reset_retired", 32'(retired), 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("fetch_ready", 32'(instr_ready), 32'd1);

      foreach (tbl[v]) begin
         run_instr(tbl[v].instr, 1);
         chk($sformatf("v%0d_op", v), 32'(d_op), 32'(tbl[v].op));
         chk($sformatf("v%0d_src", v), 32'(d_src), 32'(tbl[v].src));
         chk($sformatf("v%0d_rb", v), 32'(d_rb), 32'(tbl[v].rb));
         chk($sformatf("v%0d_m2r", v), 32'(d_m2r), 32'(tbl[v].m2r));
         chk($sformatf("v%0d_lat", v), 32'(n_cyc), 32'(tbl[v].lat));
         chk($sformatf("v%0d_pc", v), 32'(t_pc), 32'(tbl[v].n_pc));
         chk($sformatf("v%0d_rw", v), 32'(t_rw), 32'(tbl[v].n_rw));
         chk($sformatf("v%0d_br", v), 32'(t_br), 32'(tbl[v].n_br));
         chk($sformatf("v%0d_rd", v), 32'(t_rd), 32'(tbl[v].n_rd));
         chk($sformatf("v%0d_wr", v), 32'(t_wr), 32'(tbl[v].n_wr));
         if (tbl[v].n_br != 0) begin
            chk($sformatf("v%0d_br_pc", v), 32'(t_brpc), 32'd1);
            chk($sformatf("v%0d_br_op", v), 32'(br_op), 32'(tbl[v].op));
         end
         if (tbl[v].ill) begin
            chk($sformatf("v%0d_fault", v), 32'(fault), 32'd1);
            chk($sformatf("v%0d_code", v), 32'(fault_code), 32'd1);
            clear_trap();
         end else begin
            exp_ret++;
         end
         chk_retired($sformatf("v%0d_retired", v));
      end

      // LOAD with ack raised in the third MEM cycle.
      run_instr(32'h8000_0000, 3);
      chk("ld_wait_lat", 32'(n_cyc), 32'd7);
      chk("ld_wait_req", 32'(t_mr), 32'd3);
      chk("ld_wait_rd", 32'(t_rd), 32'd3);
      chk("ld_wait_wr", 32'(t_wr), 32'd0);
      chk("ld_wait_wbm2r", 32'(t_wbm2r), 32'd1);
      chk("ld_wait_pc", 32'(t_pc), 32'd1);
      exp_ret++;
      chk_retired("ld_wait_retired");

      // STORE that never gets an ack traps after MEM_TIMEOUT cycles.
      run_instr(32'h8100_0000, 0);
      chk("to_lat", 32'(n_cyc), 32'd7);
      chk("to_req", 32'(t_mr), 32'd4);
      chk("to_wr", 32'(t_wr), 32'd4);
      chk("to_pc", 32'(t_pc), 32'd0);
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_code", 32'(fault_code), 32'd2);
      chk_retired("to_retired");
      clear_trap();

      // Ack in the last allowed MEM cycle wins over the timeout.
      run_instr(32'h8100_0000, 4);
      chk("late_ack_lat", 32'(n_cyc), 32'd7);
      chk("late_ack_fault", 32'(fault), 32'd0);
      chk("late_ack_pc", 32'(t_pc), 32'd1);
      exp_ret++;
      chk_retired("late_ack_retired");

      // Reset and fault_clr together: reset wins, instr_ready stays low.
      run_instr(32'hE000_0000, 0);
      chk("trap_again", 32'(fault), 32'd1);
      reset_n = 1'b0; fault_clr = 1'b1;
      @(posedge clock); #1;
      reset_n = 1'b1; fault_clr = 1'b0;
      exp_ret = 0;
      chk("rst_vs_clr_outs", outs(), RST_OUTS);
      chk_retired("rst_vs_clr_retired");

      // Reset in the middle of a LOAD's MEM phase with an ack arriving on the same edge.
      issue(32'h8000_0000);
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("mid_mem_req", 32'(mem_req), 32'd1);
      chk("mid_mem_rd", 32'(mem_read_n), 32'd0);
      reset_n = 1'b0; mem_ack = 1'b1;
      @(posedge clock); #1;
      reset_n = 1'b1; mem_ack = 1'b0;
      chk("mem_rst_outs", outs(), RST_OUTS);
      chk("mem_rst_retired", 32'(retired), 32'd0);
      @(posedge clock); #1;
      chk("mem_rst_fetch", outs(), 32'h0002_6000);
      run_instr(32'h0000_0000, 0);
      chk("post_rst_nop_lat", 32'(n_cyc), 32'd3);
      chk("post_rst_nop_pc", 32'(t_pc), 32'd1);
      exp_ret++;
      chk_retired("post_rst_retired");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
